// File: rtl/datapath_gen2_if.sv
// datapath_gen2_if -- signal bundle between a controller and datapath_gen2.
//
// Control/data inputs of the datapath (driven by the master):
//   Din      external data source for the bus
//   Rin      per-register load enables from the bus
//   Rout     per-register bus drive selects
//   Ain, Gin, ADDRin, Doutin   load A / G (+flags) / ADDR / Dout from the bus
//   incr_pc  increment the PC (register NUM_REGS-1)
//   W_D      write strobe, delayed one cycle onto W
//   err_clr  clear the sticky bus_err flag
//   Gout, Dinout               drive G or Din onto the bus
//   alu_op   ALU operation select
// Observed outputs of the datapath (driven by the slave):
//   BUS, A, G, sumG, ADDR, Dout, W, R_flat, flags {C,N,Z}, bus_err
interface datapath_gen2_if #(
  parameter int DATA_W   = 9,
  parameter int NUM_REGS = 8
);
  logic [DATA_W-1:0]          Din;
  logic [NUM_REGS-1:0]        Rin;
  logic [NUM_REGS-1:0]        Rout;
  logic                       Ain;
  logic                       Gin;
  logic                       ADDRin;
  logic                       Doutin;
  logic                       incr_pc;
  logic                       W_D;
  logic                       err_clr;
  logic                       Gout;
  logic                       Dinout;
  logic [2:0]                 alu_op;

  logic [DATA_W-1:0]          BUS;
  logic [DATA_W-1:0]          A;
  logic [DATA_W-1:0]          G;
  logic [DATA_W-1:0]          sumG;
  logic [DATA_W-1:0]          ADDR;
  logic [DATA_W-1:0]          Dout;
  logic                       W;
  logic [NUM_REGS*DATA_W-1:0] R_flat;
  logic [2:0]                 flags;
  logic                       bus_err;

  modport master (
    output Din, Rin, Rout, Ain, Gin, ADDRin, Doutin, incr_pc, W_D, err_clr,
           Gout, Dinout, alu_op,
    input  BUS, A, G, sumG, ADDR, Dout, W, R_flat, flags, bus_err
  );

  modport slave (
    input  Din, Rin, Rout, Ain, Gin, ADDRin, Doutin, incr_pc, W_D, err_clr,
           Gout, Dinout, alu_op,
    output BUS, A, G, sumG, ADDR, Dout, W, R_flat, flags, bus_err
  );
endinterface

// File: rtl/datapath_gen2.sv
// datapath_gen2 -- single-bus register-file datapath with ALU, PC and
// bus-conflict detection.
//
// Ports:
//   clk  single clock, all state updates on the rising edge
//   rst  synchronous active-high reset, clears every register
//   io   datapath_gen2_if slave modport (controls in, BUS/registers/flags out)
//
// Behaviour summary:
//   BUS priority: Dinout > Gout > Rout[0] > ... > Rout[NUM_REGS-1], else 0.
//   More than one bus driver selected sets the sticky bus_err (set beats
//   err_clr). Register NUM_REGS-1 is the PC: a bus load beats incr_pc.
//
// Optional feature: define DATAPATH_GEN2_FLAGS_EN to build the {C,N,Z} flag
// register, loaded together with G. Undefined, flags are constant 3'b000.
module datapath_gen2 #(
  parameter int DATA_W   = 9,
  parameter int NUM_REGS = 8
) (
  input  logic            clk,
  input  logic            rst,
  datapath_gen2_if.slave  io
);

  localparam int PC_IDX = NUM_REGS - 1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_w;
  logic              r_bus_err;

  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_sumg;
  logic              w_conflict;
  logic [2:0]        w_flags;

  // Bus mux: walk from the lowest-priority source upward so the last
  // assignment that fires is the highest-priority one.
  always_comb begin
    w_bus = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (io.Rout[i]) w_bus = r_regs[i];
    end
    if (io.Gout)   w_bus = r_g;
    if (io.Dinout) w_bus = io.Din;
  end

  assign w_conflict = ($countones({io.Dinout, io.Gout, io.Rout}) > 1);

  // ALU on A and BUS, result truncated to DATA_W.
  always_comb begin
    w_sumg = '0;
    case (io.alu_op)
      3'b000:  w_sumg = r_a + w_bus;
      3'b001:  w_sumg = r_a - w_bus;
      3'b010:  w_sumg = r_a & w_bus;
      3'b011:  w_sumg = r_a | w_bus;
      3'b100:  w_sumg = r_a ^ w_bus;
      3'b101:  w_sumg = r_a << 1;
      3'b110:  w_sumg = r_a >> 1;
      default: w_sumg = w_bus;
    endcase
  end

`ifdef DATAPATH_GEN2_FLAGS_EN
  logic       w_carry;
  logic [2:0] r_flags;

  // Carry is derived without a widened adder: an unsigned add overflowed
  // exactly when the truncated sum is below A; subtract has no borrow
  // exactly when A >= BUS.
  always_comb begin
    w_carry = 1'b0;
    case (io.alu_op)
      3'b000:  w_carry = (w_sumg < r_a);
      3'b001:  w_carry = (r_a >= w_bus);
      3'b101:  w_carry = r_a[DATA_W-1];
      3'b110:  w_carry = r_a[0];
      default: w_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (io.Gin) begin
      r_flags <= {w_carry, w_sumg[DATA_W-1], (w_sumg == '0)};
    end
  end

  assign w_flags = r_flags;
`else
  assign w_flags = 3'b000;
`endif

  // All loads capture the pre-edge BUS value, so a register that drives
  // and loads the bus in the same cycle simply reloads its own value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_a       <= '0;
      r_g       <= '0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_w       <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      for (int i = 0; i < PC_IDX; i++) begin
        if (io.Rin[i]) r_regs[i] <= w_bus;
      end
      if (io.Rin[PC_IDX])   r_regs[PC_IDX] <= w_bus;
      else if (io.incr_pc)  r_regs[PC_IDX] <= r_regs[PC_IDX] + 1'b1;
      if (io.Ain)    r_a    <= w_bus;
      if (io.Gin)    r_g    <= w_sumg;
      if (io.ADDRin) r_addr <= w_bus;
      if (io.Doutin) r_dout <= w_bus;
      r_w <= io.W_D;
      // A new conflict wins over a simultaneous clear.
      if (w_conflict)       r_bus_err <= 1'b1;
      else if (io.err_clr)  r_bus_err <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign io.R_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

  assign io.BUS     = w_bus;
  assign io.sumG    = w_sumg;
  assign io.A       = r_a;
  assign io.G       = r_g;
  assign io.ADDR    = r_addr;
  assign io.Dout    = r_dout;
  assign io.W       = r_w;
  assign io.flags   = w_flags;
  assign io.bus_err = r_bus_err;

endmodule

// File: tb/tb_datapath_gen2.sv
// Table-driven bench for datapath_gen2 (DATA_W=9, NUM_REGS=8). Each vector
// drives one cycle of controls, optionally checks a combinational output
// before the edge, and queues one expected registered value that is popped
// and compared after the edge. Hand-written sequences cover reset.
module tb_datapath_gen2;
  localparam int DW = 9;
  localparam int NR = 8;

  // ctl bit map: {Dinout, Gout, Ain, Gin, ADDRin, Doutin, incr_pc, W_D, err_clr}
  localparam logic [8:0] C_D  = 9'h100;
  localparam logic [8:0] C_GO = 9'h080;
  localparam logic [8:0] C_AI = 9'h040;
  localparam logic [8:0] C_GI = 9'h020;
  localparam logic [8:0] C_AD = 9'h010;
  localparam logic [8:0] C_DO = 9'h008;
  localparam logic [8:0] C_IP = 9'h004;
  localparam logic [8:0] C_WD = 9'h002;
  localparam logic [8:0] C_EC = 9'h001;

  localparam int K_NONE = -1;
  localparam int K_A = 8, K_G = 9, K_ADDR = 10, K_DOUT = 11, K_W = 12;
  localparam int K_FLAGS = 13, K_ERR = 14, K_BUS = 15, K_SUMG = 16;

`ifdef DATAPATH_GEN2_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  typedef struct {
    logic [8:0] din;
    logic [7:0] rin;
    logic [7:0] rout;
    logic [8:0] ctl;
    logic [2:0] op;
    int         ck;
    logic [8:0] cv;
    int         cmb;
    logic [8:0] cmbv;
  } vec_t;

  typedef struct {
    int         kind;
    logic [8:0] val;
    string      tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  vec_t vt [64];
  int   nv = 0;
  sb_t  sbq [$];

  datapath_gen2_if #(.DATA_W(DW), .NUM_REGS(NR)) dif ();

  datapath_gen2 #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs(input int k);
    if (k >= 0 && k < NR) return dif.R_flat[k*DW +: DW];
    case (k)
      K_A:     return dif.A;
      K_G:     return dif.G;
      K_ADDR:  return dif.ADDR;
      K_DOUT:  return dif.Dout;
      K_W:     return {8'b0, dif.W};
      K_FLAGS: return {6'b0, dif.flags};
      K_ERR:   return {8'b0, dif.bus_err};
      K_BUS:   return dif.BUS;
      K_SUMG:  return dif.sumG;
      default: return 9'bx;
    endcase
  endfunction

  task automatic check(input string tag, input int k, input logic [8:0] exp);
    logic [8:0] act;
    act = obs(k);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [8:0] din, input logic [7:0] rin,
                     input logic [7:0] rout, input logic [8:0] ctl,
                     input logic [2:0] op, input int ck, input logic [8:0] cv,
                     input int cmb, input logic [8:0] cmbv);
    vt[nv].din = din;  vt[nv].rin = rin;  vt[nv].rout = rout;
    vt[nv].ctl = ctl;  vt[nv].op = op;    vt[nv].ck = ck;
    vt[nv].cv = cv;    vt[nv].cmb = cmb;  vt[nv].cmbv = cmbv;
    nv++;
  endtask

  task automatic drive(input vec_t v);
    dif.Din     = v.din;
    dif.Rin     = v.rin;
    dif.Rout    = v.rout;
    dif.Dinout  = v.ctl[8];
    dif.Gout    = v.ctl[7];
    dif.Ain     = v.ctl[6];
    dif.Gin     = v.ctl[5];
    dif.ADDRin  = v.ctl[4];
    dif.Doutin  = v.ctl[3];
    dif.incr_pc = v.ctl[2];
    dif.W_D     = v.ctl[1];
    dif.err_clr = v.ctl[0];
    dif.alu_op  = v.op;
  endtask

  // Wait for the edge, then pop and compare every queued expectation.
  task automatic edge_and_drain();
    sb_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, e.kind, e.val);
    end
  endtask

  task automatic push_all_zero(input string pfx);
    sb_t e;
    for (int k = 0; k <= K_ERR; k++) begin
      e.kind = k;
      e.val  = 9'h000;
      e.tag  = $sformatf("%s_k%0d", pfx, k);
      sbq.push_back(e);
    end
  endtask

  initial begin
    vec_t v;
    sb_t  e;

    // Stimulus table: din, rin, rout, ctl, op, check kind/value, comb kind/value
    add(9'h1A5, 8'h04, 8'h00, C_D,        3'd0, 2,       9'h1A5, K_BUS,  9'h1A5);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_ERR,   9'h000, K_BUS,  9'h000);
    add(9'h0FF, 8'h00, 8'h00, C_D|C_AI,   3'd0, K_A,     9'h0FF, K_NONE, 9'h000);
    add(9'h001, 8'h02, 8'h00, C_D,        3'd0, 1,       9'h001, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h02, C_GI,       3'd0, K_G,     9'h100, K_SUMG, 9'h100);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_FLAGS, FE ? 9'h002 : 9'h000, K_NONE, 9'h000);
    add(9'h005, 8'h00, 8'h00, C_D|C_AI,   3'd0, K_A,     9'h005, K_NONE, 9'h000);
    add(9'h005, 8'h00, 8'h00, C_D|C_GI,   3'd1, K_G,     9'h000, K_SUMG, 9'h000);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_FLAGS, FE ? 9'h005 : 9'h000, K_NONE, 9'h000);
    add(9'h1FF, 8'h80, 8'h00, C_D,        3'd0, 7,       9'h1FF, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, C_IP,       3'd0, 7,       9'h000, K_NONE, 9'h000);
    add(9'h040, 8'h80, 8'h00, C_D|C_IP,   3'd0, 7,       9'h040, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, C_IP,       3'd0, 7,       9'h041, K_NONE, 9'h000);
    add(9'h0F0, 8'h00, 8'h00, C_D|C_AD,   3'd0, K_ADDR,  9'h0F0, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h04, C_DO,       3'd0, K_DOUT,  9'h1A5, K_BUS,  9'h1A5);
    add(9'h000, 8'h00, 8'h00, C_WD,       3'd0, K_W,     9'h001, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_W,     9'h000, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, C_GO|C_GI,  3'd0, K_G,     9'h005, K_SUMG, 9'h005);
    add(9'h000, 8'h00, 8'h00, C_GO|C_GI,  3'd0, K_G,     9'h00A, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h08, C_GO,       3'd0, K_ERR,   9'h001, K_BUS,  9'h00A);
    add(9'h000, 8'h00, 8'h08, C_GO|C_EC,  3'd0, K_ERR,   9'h001, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, C_EC,       3'd0, K_ERR,   9'h000, K_NONE, 9'h000);
    add(9'h123, 8'h10, 8'h01, C_D,        3'd0, 4,       9'h123, K_BUS,  9'h123);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_ERR,   9'h001, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, C_EC,       3'd0, K_ERR,   9'h000, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd2, K_G,     9'h004, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd3, K_G,     9'h00D, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd4, K_G,     9'h009, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd5, K_G,     9'h00A, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd6, K_G,     9'h002, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_FLAGS, FE ? 9'h004 : 9'h000, K_NONE, 9'h000);
    add(9'h00C, 8'h00, 8'h00, C_D|C_GI,   3'd7, K_G,     9'h00C, K_NONE, 9'h000);
    add(9'h006, 8'h00, 8'h00, C_D|C_GI,   3'd1, K_G,     9'h1FF, K_SUMG, 9'h1FF);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_FLAGS, FE ? 9'h002 : 9'h000, K_NONE, 9'h000);
    add(9'h1FC, 8'h00, 8'h00, C_D|C_GI,   3'd0, K_G,     9'h001, K_NONE, 9'h000);
    add(9'h000, 8'h00, 8'h00, 9'h000,     3'd0, K_FLAGS, FE ? 9'h004 : 9'h000, K_NONE, 9'h000);

    // Power-on reset: idle controls, every register must read zero.
    v = vt[1];
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_all_zero("por");
    edge_and_drain();
    $display("[TB] reset: all registers checked for zero");
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      drive(vt[i]);
      #1;
      if (vt[i].cmb != K_NONE) check($sformatf("v%0d_comb%0d", i, vt[i].cmb), vt[i].cmb, vt[i].cmbv);
      e.kind = vt[i].ck;
      e.val  = vt[i].cv;
      e.tag  = $sformatf("v%0d_k%0d", i, vt[i].ck);
      sbq.push_back(e);
      edge_and_drain();
      $display("[TB] vec %0d: kind %0d expected 0x%0h observed 0x%0h",
               i, vt[i].ck, vt[i].cv, obs(vt[i].ck));
    end

    // Mid-sequence reset with every load, increment, a bus conflict and a
    // write strobe active: reset must win everywhere.
    v.din = 9'h0AA; v.rin = 8'hFF; v.rout = 8'h00;
    v.ctl = C_D | C_GO | C_AI | C_GI | C_AD | C_DO | C_IP | C_WD | C_EC;
    v.op  = 3'd0;
    drive(v);
    rst = 1'b1;
    #1;
    check("rst_comb_bus", K_BUS, 9'h0AA);
    push_all_zero("midrst");
    edge_and_drain();
    $display("[TB] mid-sequence reset: all registers checked for zero");

    // Release reset with idle controls: state must hold at zero.
    v = vt[1];
    drive(v);
    rst = 1'b0;
    e.kind = K_G;   e.val = 9'h000; e.tag = "post_rst_g";  sbq.push_back(e);
    e.kind = 7;     e.val = 9'h000; e.tag = "post_rst_pc"; sbq.push_back(e);
    edge_and_drain();
    $display("[TB] post-reset idle cycle checked");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_gen2.md
DATAPATH_GEN2 -- requirements
Module: datapath_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning width of the bus, every register and the ALU.
REQ-002 SHALL have parameter NUM_REGS, default 8, range 2..16, meaning the general register count; register NUM_REGS-1 is the PC.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Din, input, DATA_W: external data source for the bus.
REQ-006 SHALL have port Rin, input, NUM_REGS: per-register load enables from the bus.
REQ-007 SHALL have port Rout, input, NUM_REGS: per-register bus drive selects.
REQ-008 SHALL have ports Ain, Gin, ADDRin, Doutin, incr_pc, W_D, err_clr, input, 1 bit each: load A, load G and flags, load ADDR, load Dout, increment PC, write strobe D-input, clear bus_err.
REQ-009 SHALL have ports Gout and Dinout, input, 1 bit each: drive G or Din onto the bus.
REQ-010 SHALL have port alu_op, input, 3 bits: ALU operation select.
REQ-011 SHALL have ports BUS, A, G, sumG, ADDR, Dout, output, DATA_W each.
REQ-012 SHALL have port W, output, 1 bit: registered W_D.
REQ-013 SHALL have port R_flat, output, NUM_REGS*DATA_W: register i on bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have ports flags (output, 3 bits: {C,N,Z}) and bus_err (output, 1 bit, sticky).

Function
REQ-015 BUS SHALL be combinational, with priority Dinout > Gout > Rout[0] > ... > Rout[NUM_REGS-1]; no select asserted -> BUS = 0.
REQ-016 A drive-select count across Dinout, Gout and Rout greater than 1 SHALL set bus_err at the next edge; BUS still follows the REQ-015 priority.
REQ-017 bus_err SHALL stay set until err_clr; err_clr in the same cycle as a new conflict leaves bus_err set (set wins).
REQ-018 Registers 0..NUM_REGS-2, A, ADDR and Dout SHALL load BUS at the edge where their enable is high; load latency is 1 cycle and the register otherwise holds.
REQ-019 PC (register NUM_REGS-1): Rin[NUM_REGS-1] SHALL load BUS; else incr_pc SHALL add 1 modulo 2^DATA_W, so all-ones wraps to 0; load beats incr_pc.
REQ-020 W SHALL register W_D every cycle (1-cycle delay, no enable).
REQ-021 sumG SHALL be the combinational ALU result of A and BUS: 000 A+BUS, 001 A-BUS, 010 A&BUS, 011 A|BUS, 100 A^BUS, 101 A<<1, 110 A>>1 logical, 111 BUS; the result is truncated to DATA_W.
REQ-022 G SHALL load sumG at the edge where Gin is high.
REQ-023 A register loading from a BUS that it drives in the same cycle SHALL capture the pre-edge value (no combinational loop through the register).

Reset
REQ-024 With rst high at an edge, every register SHALL clear to 0: R0..R(NUM_REGS-1), A, G, ADDR, Dout, W, flags and bus_err.
REQ-025 rst SHALL override all enables, incr_pc and err_clr in the same cycle, including mid-operation.
REQ-026 Combinational outputs (BUS, sumG) SHALL follow their inputs during reset.

Configuration
REQ-027 Macro DATAPATH_GEN2_FLAGS_EN defined: flags SHALL load with G when Gin is high, as follows: Z = (sumG==0); N = sumG[DATA_W-1]; C = carry-out for 000, no-borrow (carry of A+~BUS+1) for 001, shifted-out bit for 101/110, otherwise 0.
REQ-028 Macro DATAPATH_GEN2_FLAGS_EN undefined: no flag logic SHALL exist and flags SHALL be tied to 3'b000.

Verification
REQ-029 Reset, then Din=0x1A5 with Dinout=1 and Rin[2]=1 -> next cycle R2=0x1A5, bus_err=0.
REQ-030 A=0x0FF, Rout[1]=1 with R1=0x001, alu_op=000, Gin=1 -> G=0x100; with FLAGS_EN, flags C=0, N=1, Z=0.
REQ-031 A=5, BUS=5, alu_op=001, Gin=1 -> G=0; with FLAGS_EN, Z=1, C=1; without FLAGS_EN, flags=000.
REQ-032 PC=0x1FF, incr_pc=1 -> PC=0x000; incr_pc=1 and Rin[7]=1 with BUS=0x040 in the same cycle -> PC=0x040.
REQ-033 Gout=1 and Rout[3]=1 -> BUS=G and bus_err=1 next cycle; err_clr with no conflict -> bus_err=0; err_clr during a conflict -> bus_err stays 1.
REQ-034 Mid-sequence rst pulse with Ain=1, Gin=1, incr_pc=1 -> all registers, flags and bus_err read 0 the next cycle.
